mrd_out_scaler: RTL and testbench
=================================

Name: mrd_out_scaler

Overview:
- Output stage directly downstream of the mixed-radix DFT memory top; consumes its source stream (18-bit I/Q plus block-floating-point exponent) and produces fixed-point WOUT-bit samples at one common output exponent.
- Also regenerates clean sop/eop framing from dftpts, checks packet length and flags saturation per packet.
- Fixed 3-cycle streaming pipeline, no backpressure, since the memory source stage cannot stall.

Parameters:
- WIN, 18, input sample width per real/imag (signed)
- WOUT, 16, output sample width per real/imag (signed)
- WEXP, 6, exponent width (signed two's complement)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample strobe
- in_sop  in  1  first sample of packet (qualified by in_valid)
- in_eop  in  1  last sample of packet (qualified by in_valid)
- in_real  in  WIN  signed real part
- in_imag  in  WIN  signed imaginary part
- in_exp  in  WEXP  signed packet exponent; sampled only on sop
- in_dftpts  in  12  packet length (1..4095); sampled only on sop
- cfg_tgt_exp  in  WEXP  signed target exponent; sampled only on sop
- out_valid  out  1  output sample strobe
- out_sop  out  1  regenerated first-sample flag
- out_eop  out  1  regenerated last-sample flag
- out_real  out  WOUT  scaled/saturated real part
- out_imag  out  WOUT  scaled/saturated imaginary part
- out_sat  out  1  sticky per packet: any saturation so far; valid with out_eop
- len_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Reset mid-packet discards the packet and emits no eop.
- Scaling: sh = in_exp - cfg_tgt_exp, computed at WEXP+1 bits and clamped to [-15,+15].
  - sh>=0: value << sh, saturated to [-2^(WOUT-1), 2^(WOUT-1)-1].
  - sh<0: arithmetic right shift by -sh with round-half-up (add 2^(-sh-1) before the shift), then saturate.
  - The WIN-to-WOUT reduction is part of the saturation, not a truncation.
- Latency: exactly 3 cycles from an accepted in_valid to out_valid.
  - S1: register inputs and sh.
  - S2: shift and round.
  - S3: saturate and output.
- Sample accounting: samples accepted in IDLE with in_sop=0 are dropped. No output is produced for them.
- FSM, with cnt = samples accepted in the current packet:
  - IDLE: on in_valid & in_sop, latch in_dftpts/in_exp/cfg_tgt_exp, accept the sample with out_sop=1, cnt=1, clear sat. If in_dftpts==1 the same sample carries out_eop and the FSM stays in IDLE. Otherwise go to RUN.
  - RUN, in_valid & in_sop: restart. Pulse len_err, the previous packet gets no eop, treat the sample as a new IDLE sop.
  - RUN, in_valid & cnt==dftpts-1: the sample carries out_eop. If in_eop=0, pulse len_err. Go to IDLE.
  - RUN, in_valid & in_eop & cnt<dftpts-1 (early eop): the sample carries out_eop, pulse len_err, go to IDLE.
  - RUN, in_valid otherwise: pass the sample, cnt++.
  - IDLE, in_valid & in_eop & !in_sop (late eop): pulse len_err, drop the sample.
- Exponent and length stay constant for the whole packet, even if the inputs change mid-packet.
- out_sop/out_eop/len_err are aligned to the corresponding output sample (len_err delayed by 3 like the data). A dropped-sample len_err is issued 3 cycles after that input.
- out_sat is sticky from the packet's first saturated sample and holds until the next out_sop clears it.
- Gaps in in_valid are allowed anywhere; out_valid reproduces the same gap pattern.

Optional Feature:
- Macro MRD_OUT_SAT_CNT_EN.
- Defined: adds output port sat_cnt [12:0], the number of saturated real-or-imag samples in the current packet. It resets on out_sop (the sop sample is counted), is valid with out_eop and saturates at 4095.
- Undefined: no port, no counter logic. out_sat is unchanged in both builds.

Test Plan:
- 8-sample packet, in_exp=2, cfg_tgt_exp=0, inputs 1..8 -> outputs 4..32, out_sop on the first and out_eop on the 8th output, each 3 cycles after its input; out_sat=0, len_err never.
- sh=-2 with inputs 5, 6, -5, -6 -> outputs 1, 2, -1, -1 (round-half-up); sh=+15 with input 1 -> 32767, out_sat=1 at eop.
- in_dftpts=4 but in_eop on the 2nd sample -> out_eop on the 2nd output, len_err pulse aligned with it; a following sop packet processes normally.
- in_dftpts=4 with in_eop absent on the 4th sample -> out_eop on the 4th output plus len_err. A stray in_eop sample next cycle -> dropped, second len_err 3 cycles later.
- in_sop at cnt=3 of a 6-sample packet -> len_err pulse, new packet's out_sop; assert rst mid-packet -> all outputs 0 immediately, no out_eop afterwards.
- With MRD_OUT_SAT_CNT_EN defined: 10-sample packet with 3 saturating samples -> sat_cnt=3 at out_eop, and 0/1 after the next out_sop.

Source files
------------

// File: rtl/mrd_out_scaler.sv
// mrd_out_scaler: block-floating-point to fixed-point output stage behind the
// mixed-radix DFT memory. It rescales to one common exponent, regenerates
// sop/eop from dftpts, checks packet length and flags saturation per packet.
// Latency: fixed 3 cycles from an accepted input sample to out_valid.
// Backpressure: none. The upstream memory stage cannot stall, so every
// accepted sample appears 3 cycles later with the same gap pattern.
// Optional build macro MRD_OUT_SAT_CNT_EN adds the sat_cnt output port,
// which counts saturated samples per packet.

module mrd_out_scaler #(
    parameter int WIN  = 18,
    parameter int WOUT = 16,
    parameter int WEXP = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic signed [WIN-1:0]  in_real,
    input  logic signed [WIN-1:0]  in_imag,
    input  logic signed [WEXP-1:0] in_exp,
    input  logic [11:0]            in_dftpts,
    input  logic signed [WEXP-1:0] cfg_tgt_exp,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic signed [WOUT-1:0] out_real,
    output logic signed [WOUT-1:0] out_imag,
    output logic                   out_sat,
    output logic                   len_err
`ifdef MRD_OUT_SAT_CNT_EN
    ,
    output logic [12:0]            sat_cnt
`endif
);

    // The intermediate width holds an input shifted left by up to 15 bits.
    // Saturation then narrows it to WOUT bits.
    localparam int WW = WIN + 16;
    localparam int SMAX_I = (2 ** (WOUT - 1)) - 1;
    localparam logic signed [WW-1:0] SAT_MAX = WW'(SMAX_I);
    localparam logic signed [WW-1:0] SAT_MIN = WW'(-SMAX_I - 1);
    localparam logic signed [WEXP:0] SH_HI = 15;
    localparam logic signed [WEXP:0] SH_LO = -15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [11:0]            cnt;
    logic [11:0]            dftpts_q;
    logic signed [4:0]      sh_q;
    logic signed [WEXP:0]   sh_diff;
    logic signed [4:0]      sh_new;

    // Stage 1 registers: the framing decision, the shift amount and the raw sample.
    logic                   s1_vld, s1_sop, s1_eop, s1_lerr;
    logic signed [4:0]      s1_sh;
    logic signed [WIN-1:0]  s1_re, s1_im;

    // Stage 2 registers: the shifted and rounded wide value.
    logic                   s2_vld, s2_sop, s2_eop, s2_lerr;
    logic signed [WW-1:0]   s2_re, s2_im;

    // Stage 3 combinational saturation result.
    logic                   sat_re, sat_im, sat_now;
    logic signed [WOUT-1:0] clip_re, clip_im;

    // Shift a sample by sh. A positive sh shifts left. A negative sh does an
    // arithmetic right shift with round-half-up.
    function automatic logic signed [WW-1:0] scale(input logic signed [WIN-1:0] x,
                                                   input logic signed [4:0]     sh);
        logic signed [WW-1:0] xe;
        logic signed [WW-1:0] rnd;
        logic [3:0]           k;
        xe  = x;
        rnd = '0;
        k   = 4'(-sh);
        if (!sh[4]) begin
            return xe <<< sh[3:0];
        end
        rnd = WW'(1) <<< (k - 4'd1);
        return (xe + rnd) >>> k;
    endfunction

    // Report whether a wide value lies outside the WOUT output range.
    function automatic logic over_range(input logic signed [WW-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Clamp a wide value to the WOUT output range.
    function automatic logic signed [WOUT-1:0] clip(input logic signed [WW-1:0] v);
        if (v > SAT_MAX) begin
            return WOUT'(SAT_MAX);
        end
        if (v < SAT_MIN) begin
            return WOUT'(SAT_MIN);
        end
        return WOUT'(v);
    endfunction

    // Compute the packet shift amount at full precision, clamped to +/-15.
    always_comb begin
        sh_diff = (WEXP+1)'(in_exp) - (WEXP+1)'(cfg_tgt_exp);
        sh_new  = '0;
        if (sh_diff > SH_HI) begin
            sh_new = 5'sd15;
        end else if (sh_diff < SH_LO) begin
            sh_new = -5'sd15;
        end else begin
            sh_new = 5'(sh_diff);
        end
    end

    // Framing FSM. It accepts or drops each input sample and registers the
    // stage-1 control flags. Length and shift are held for the whole packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dftpts_q <= '0;
            sh_q     <= '0;
            s1_vld   <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_lerr  <= 1'b0;
            s1_sh    <= '0;
        end else begin
            s1_vld  <= 1'b0;
            s1_sop  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_lerr <= 1'b0;
            if (in_valid && in_sop) begin
                // A sop always starts a new packet. In RUN the old packet is
                // abandoned without an eop and the restart is flagged.
                dftpts_q <= in_dftpts;
                sh_q     <= sh_new;
                s1_sh    <= sh_new;
                s1_vld   <= 1'b1;
                s1_sop   <= 1'b1;
                s1_lerr  <= (state == RUN);
                cnt      <= 12'd1;
                if (in_dftpts == 12'd1) begin
                    s1_eop <= 1'b1;
                    state  <= IDLE;
                end else begin
                    state  <= RUN;
                end
            end else if (in_valid) begin
                case (state)
                    RUN: begin
                        s1_vld <= 1'b1;
                        s1_sh  <= sh_q;
                        if (cnt == dftpts_q - 12'd1) begin
                            // Expected last sample. A missing in_eop is a length error.
                            s1_eop  <= 1'b1;
                            s1_lerr <= !in_eop;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else if (in_eop) begin
                            // An early eop closes the packet short.
                            s1_eop  <= 1'b1;
                            s1_lerr <= 1'b1;
                            cnt     <= '0;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 12'd1;
                        end
                    end
                    default: begin
                        // Outside a packet, drop the sample. A late eop is
                        // reported as a length error but produces no data.
                        s1_lerr <= in_eop;
                    end
                endcase
            end
        end
    end

    // Stage 1: capture the raw sample alongside the framing decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_re <= '0;
            s1_im <= '0;
        end else if (in_valid) begin
            s1_re <= in_real;
            s1_im <= in_imag;
        end
    end

    // Stage 2: apply the shift and rounding at full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            s2_sop  <= 1'b0;
            s2_eop  <= 1'b0;
            s2_lerr <= 1'b0;
            s2_re   <= '0;
            s2_im   <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_sop  <= s1_sop;
            s2_eop  <= s1_eop;
            s2_lerr <= s1_lerr;
            if (s1_vld) begin
                s2_re <= scale(s1_re, s1_sh);
                s2_im <= scale(s1_im, s1_sh);
            end
        end
    end

    // Saturate both components and detect whether either one clipped.
    always_comb begin
        sat_re  = over_range(s2_re);
        sat_im  = over_range(s2_im);
        sat_now = s2_vld && (sat_re || sat_im);
        clip_re = clip(s2_re);
        clip_im = clip(s2_im);
    end

    // Stage 3: register the outputs. The sop sample restarts the sticky
    // saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            len_err   <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s2_vld;
            out_sop   <= s2_vld && s2_sop;
            out_eop   <= s2_vld && s2_eop;
            len_err   <= s2_lerr;
            if (s2_vld) begin
                out_real <= clip_re;
                out_imag <= clip_im;
                out_sat  <= s2_sop ? sat_now : (out_sat || sat_now);
            end
        end
    end

`ifdef MRD_OUT_SAT_CNT_EN
    // Count saturated samples per packet, including the sop sample.
    // The count stops at 4095.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (s2_vld) begin
            if (s2_sop) begin
                sat_cnt <= {12'd0, sat_now};
            end else if (sat_now && (sat_cnt < 13'd4095)) begin
                sat_cnt <= sat_cnt + 13'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mrd_out_scaler.sv
// Testbench for mrd_out_scaler. Directed packets push their hand-derived
// expected outputs, with arrival cycles, into a scoreboard queue. A monitor
// on the falling edge pops and compares whenever out_valid or len_err is set.
module tb_mrd_out_scaler;

    localparam int WIN  = 18;
    localparam int WOUT = 16;
    localparam int WEXP = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_sop = 1'b0;
    logic                   in_eop = 1'b0;
    logic signed [WIN-1:0]  in_real = '0;
    logic signed [WIN-1:0]  in_imag = '0;
    logic signed [WEXP-1:0] in_exp = '0;
    logic [11:0]            in_dftpts = '0;
    logic signed [WEXP-1:0] cfg_tgt_exp = '0;
    logic                   out_valid, out_sop, out_eop, out_sat, len_err;
    logic signed [WOUT-1:0] out_real, out_imag;
`ifdef MRD_OUT_SAT_CNT_EN
    logic [12:0]            sat_cnt;
`endif

    mrd_out_scaler #(.WIN(WIN), .WOUT(WOUT), .WEXP(WEXP)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .in_exp      (in_exp),
        .in_dftpts   (in_dftpts),
        .cfg_tgt_exp (cfg_tgt_exp),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_sat     (out_sat),
        .len_err     (len_err)
`ifdef MRD_OUT_SAT_CNT_EN
        ,
        .sat_cnt     (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit vld, sop, eop, lerr;
        int re, im;
        bit chks;
        bit sat;
        int sc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int n_pass = 0;
    int n_total = 0;

    // Packet-level settings. drv copies them onto the ports with each sample.
    int g_exp = 0, g_tgt = 0, g_dft = 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic drv(input bit v, input bit s, input bit eo, input int re, input int im);
        @(posedge clk);
        #2;
        in_valid    = v;
        in_sop      = s;
        in_eop      = eo;
        in_real     = WIN'(re);
        in_imag     = WIN'(im);
        in_exp      = WEXP'(g_exp);
        cfg_tgt_exp = WEXP'(g_tgt);
        in_dftpts   = 12'(g_dft);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic push(input bit v, input bit xs, input bit xe, input bit xl,
                        input int xre, input int xim, input bit chks, input bit xsat, input int xsc);
        exp_t x;
        x.t = cyc + 3; x.vld = v; x.sop = xs; x.eop = xe; x.lerr = xl;
        x.re = xre; x.im = xim; x.chks = chks; x.sat = xsat; x.sc = xsc;
        q.push_back(x);
    endtask

    // Drive one valid sample and queue its expected output.
    task automatic smp(input bit s, input bit eo, input int re, input int im,
                       input bit xs, input bit xe, input bit xl, input int xre, input int xim,
                       input bit chks, input bit xsat, input int xsc);
        drv(1'b1, s, eo, re, im);
        push(1'b1, xs, xe, xl, xre, xim, chks, xsat, xsc);
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && (out_valid || len_err)) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got valid=%0d eop=%0d len_err=%0d, expected none (cycle %0d)",
                         out_valid, out_eop, len_err, cyc);
            end else begin
                e = q.pop_front();
                chk("arrival_cycle", cyc, e.t);
                chk("out_valid", int'(out_valid), int'(e.vld));
                chk("out_sop", int'(out_sop), int'(e.sop));
                chk("out_eop", int'(out_eop), int'(e.eop));
                chk("len_err", int'(len_err), int'(e.lerr));
                if (e.vld) begin
                    chk("out_real", int'(out_real), e.re);
                    chk("out_imag", int'(out_imag), e.im);
                end
                if (e.chks) begin
                    chk("out_sat", int'(out_sat), int'(e.sat));
`ifdef MRD_OUT_SAT_CNT_EN
                    chk("sat_cnt", int'(sat_cnt), e.sc);
`endif
                end
            end
        end
    end

    initial begin
        // Check the state held during reset.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sop", int'(out_sop), 0);
        chk("rst_out_eop", int'(out_eop), 0);
        chk("rst_out_real", int'(out_real), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_len_err", int'(len_err), 0);
        rst = 1'b0;

        // 8-sample packet, shift +2, with a one-cycle input gap.
        g_exp = 2; g_tgt = 0; g_dft = 8;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) idle();
            smp(i == 1, i == 8, i, -i, i == 1, i == 8, 1'b0, 4 * i, -4 * i, i == 8, 1'b0, 0);
        end
        idle();

        // Shift -2 with round-half-up. Exponent and length change mid-packet and must be ignored.
        g_exp = 0; g_tgt = 2; g_dft = 4;
        smp(1, 0, 5, 7, 1, 0, 0, 1, 2, 0, 0, 0);
        g_exp = 9; g_tgt = -3; g_dft = 2;
        smp(0, 0, 6, 2, 0, 0, 0, 2, 1, 0, 0, 0);
        smp(0, 0, -5, -2, 0, 0, 0, -1, 0, 0, 0, 0);
        smp(0, 1, -6, -7, 0, 1, 0, -1, -2, 1, 0, 0);
        idle();

        // Single-sample packets: clamp, saturation and exact-half rounding.
        g_dft = 1;
        g_exp = 15; g_tgt = 0;
        smp(1, 1, 1, -1, 1, 1, 0, 32767, -32768, 1, 1, 1);
        g_exp = 31; g_tgt = -32;
        smp(1, 1, 0, -1, 1, 1, 0, 0, -32768, 1, 0, 0);
        g_exp = -32; g_tgt = 31;
        smp(1, 1, 100000, -131072, 1, 1, 0, 3, -4, 1, 0, 0);
        g_exp = 1; g_tgt = 0;
        smp(1, 1, -131072, 100, 1, 1, 0, -32768, 200, 1, 1, 1);
        g_exp = 0; g_tgt = 1;
        smp(1, 1, 3, -3, 1, 1, 0, 2, -1, 1, 0, 0);
        idle();

        // Early eop on the 2nd sample of a 4-sample packet, then a normal packet that saturates.
        g_exp = 0; g_tgt = 0; g_dft = 4;
        smp(1, 0, 10, 11, 1, 0, 0, 10, 11, 0, 0, 0);
        smp(0, 1, 20, 21, 0, 1, 1, 20, 21, 1, 0, 0);
        g_dft = 2;
        smp(1, 0, 40000, 30, 1, 0, 0, 32767, 30, 0, 0, 0);
        smp(0, 1, 40, -40000, 0, 1, 0, 40, -32768, 1, 1, 2);
        idle();

        // Missing eop on the 4th sample, then a stray eop sample that is dropped.
        g_dft = 4;
        smp(1, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        smp(0, 0, 2, 2, 0, 0, 0, 2, 2, 0, 0, 0);
        smp(0, 0, 3, 3, 0, 0, 0, 3, 3, 0, 0, 0);
        smp(0, 0, 4, 4, 0, 1, 1, 4, 4, 1, 0, 0);
        drv(1, 0, 1, 99, 99);
        push(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle();

        // sop arrives at cnt=3 of a 6-sample packet: restart with len_err on the new sop.
        g_dft = 6;
        smp(1, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        smp(0, 0, 2, 2, 0, 0, 0, 2, 2, 0, 0, 0);
        smp(0, 0, 3, 3, 0, 0, 0, 3, 3, 0, 0, 0);
        g_dft = 3;
        smp(1, 0, 50, 50, 1, 0, 1, 50, 50, 0, 0, 0);
        smp(0, 0, 60, 60, 0, 0, 0, 60, 60, 0, 0, 0);
        smp(0, 1, 70, 70, 0, 1, 0, 70, 70, 1, 0, 0);
        drv(1, 0, 0, 5, 5);    // no sop while IDLE: dropped silently
        idle();

        // Assert reset mid-packet: outputs clear at once and no eop follows.
        g_dft = 5;
        smp(1, 0, 8, 8, 1, 0, 0, 8, 8, 0, 0, 0);
        smp(0, 0, 9, 9, 0, 0, 0, 9, 9, 0, 0, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_real", int'(out_real), 0);
        chk("midrst_out_imag", int'(out_imag), 0);
        chk("midrst_out_eop", int'(out_eop), 0);
        chk("midrst_len_err", int'(len_err), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        drv(1, 0, 0, 10, 10);
        drv(1, 0, 0, 11, 11);
        drv(1, 0, 0, 12, 12);
        repeat (6) idle();

        // 10-sample packet with 3 saturating samples, then two single-sample packets.
        g_dft = 10;
        for (int i = 1; i <= 10; i++) begin
            int re, im, xre, xim;
            re = 100 * i; im = -100 * i; xre = re; xim = im;
            if (i == 2) begin re = 40000; xre = 32767; end
            if (i == 5) begin im = -40000; xim = -32768; end
            if (i == 9) begin re = -50000; xre = -32768; end
            smp(i == 1, i == 10, re, im, i == 1, i == 10, 0, xre, xim, i == 10, 1, 3);
        end
        g_dft = 1;
        smp(1, 1, 7, 7, 1, 1, 0, 7, 7, 1, 0, 0);
        smp(1, 1, 131071, 0, 1, 1, 0, 32767, 0, 1, 1, 1);
        idle();

        // Let the pipeline drain, with a bounded wait.
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d outstanding expected outputs, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
